// File: rtl/lbus_pkg.sv
// Shared types and default constants for the lbus trace sequencer and its word writer.
package lbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_SEND_DATA,
    ST_SEND_START,
    ST_WAIT_END
  } state_t;

  // One 32-bit write is two address/data pairs, low half first.
  typedef enum logic [1:0] {
    L_ADDR = 2'b00,
    L_DATA = 2'b01,
    H_ADDR = 2'b10,
    H_DATA = 2'b11
  } step_t;

  localparam logic [15:0] CTRL_ADDR_DEF = 16'h0002;
  localparam logic [15:0] START_VAL_DEF = 16'h0001;

endpackage

// File: rtl/lbus_word_writer.sv
// Issues one 32-bit write as four lbus steps: low addr, low data, high addr, high data.
// A go on the done cycle chains the next word with no idle gap.
module lbus_word_writer
  import lbus_pkg::*;
(
  input  logic        lbus_clkn,
  input  logic        lbus_rst,
  input  logic        go,
  input  logic [15:0] addr,
  input  logic [31:0] data,
  output logic [15:0] di,
  output logic        wrn,
  output logic        done
);

  logic        active;
  step_t       step;
  logic [15:0] addr_q;
  logic [31:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge lbus_clkn) begin
    if (lbus_rst) begin
      active <= 1'b0;
      step   <= L_ADDR;
      addr_q <= '0;
      data_q <= '0;
    end else if (go) begin
      active <= 1'b1;
      step   <= L_ADDR;
      addr_q <= addr;
      data_q <= data;
    end else if (active) begin
      step <= step_t'(step + 2'd1);
      if (step == H_DATA) active <= 1'b0;
    end
  end

  // NOTE: outputs get a default first so this block cannot infer a latch.
  always_comb begin
    di  = '0;
    wrn = 1'b0;
    if (active) begin
      unique case (step)
        L_ADDR: begin di = addr_q;          wrn = 1'b1; end
        L_DATA: di = data_q[15:0];
        H_ADDR: begin di = addr_q + 16'd1;  wrn = 1'b1; end
        H_DATA: di = data_q[31:16];
      endcase
    end
  end

  assign done = active && (step == H_DATA);

endmodule

// File: rtl/lbus_trace_sequencer.sv
// lbus master for power-trace capture: pause, write DATA_NUM operand words, write the
// start command, then wait for the target's end strobe (or time out) and repeat while run.
module lbus_trace_sequencer
  import lbus_pkg::*;
#(
  parameter int          DATA_NUM    = 7,
  parameter int          PAUSE_CYC   = 20,
  parameter logic [15:0] BASE_ADDR   = 16'h0100,
  parameter logic [15:0] LAST_ADDR   = 16'h0110,
  parameter logic [15:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter logic [15:0] START_VAL   = START_VAL_DEF,
  parameter logic [31:0] SEED        = 32'h00010000,
  parameter int          TIMEOUT_CYC = 1024
)(
  input  logic        lbus_clkn,
  input  logic        lbus_rst,
  input  logic        run,
  input  logic        tgt_endn,
  output logic [15:0] lbus_di_a,
  output logic        lbus_wrn,
  output logic        lbus_rdn,
  output logic        busy,
  output logic [15:0] trace_cnt,
  output logic        timeout_err
);

  localparam int IDX_W = $clog2(DATA_NUM + 1);
  localparam int PCW   = $clog2(PAUSE_CYC + 1);
  localparam int TMW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_NUM - 1);
  localparam logic [IDX_W-1:0] WORDS      = IDX_W'(DATA_NUM);
  localparam logic [PCW-1:0]   PAUSE_LAST = PCW'(PAUSE_CYC - 1);
  localparam logic [TMW-1:0]   TIMER_LAST = TMW'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [PCW-1:0]   pause_cnt;
  logic [IDX_W-1:0] word_idx;    // index of the next word to hand to the writer
  logic [TMW-1:0]   timer;
  logic             start_step;
  logic [31:0]      operand;

  logic        w_go;
  logic [15:0] w_addr;
  logic [15:0] w_di;
  logic        w_wrn;
  logic        w_done;

  logic [15:0] bus_di;
  logic        bus_wrn;
  state_t      end_state;

  // The final word sits apart from the contiguous block of the others.
  function automatic logic [15:0] word_addr(input logic [IDX_W-1:0] k);
    return (k < LAST_IDX) ? BASE_ADDR + (16'(k) << 1) : LAST_ADDR;
  endfunction

  lbus_word_writer u_word_writer (
    .lbus_clkn (lbus_clkn),
    .lbus_rst  (lbus_rst),
    .go        (w_go),
    .addr      (w_addr),
    .data      (operand),
    .di        (w_di),
    .wrn       (w_wrn),
    .done      (w_done)
  );

  assign w_addr    = word_addr(word_idx);
  assign end_state = run ? ST_PAUSE : ST_IDLE;

  always_comb begin
    w_go = 1'b0;
    case (state)
      ST_PAUSE:     w_go = (pause_cnt == PAUSE_LAST);
      ST_SEND_DATA: w_go = w_done && (word_idx != WORDS);
      default:      ;
    endcase
  end

  always_comb begin
    bus_di  = '0;
    bus_wrn = 1'b0;
    case (state)
      ST_SEND_DATA: begin
        bus_di  = w_di;
        bus_wrn = w_wrn;
      end
      ST_SEND_START: begin
        bus_di  = start_step ? START_VAL : CTRL_ADDR;
        bus_wrn = !start_step;
      end
      default: ;
    endcase
  end

  always_ff @(negedge lbus_clkn) begin
    if (lbus_rst) begin
      state       <= ST_IDLE;
      pause_cnt   <= '0;
      word_idx    <= '0;
      timer       <= '0;
      start_step  <= 1'b0;
      operand     <= SEED;
      trace_cnt   <= '0;
      timeout_err <= 1'b0;
      lbus_di_a   <= '0;
      lbus_wrn    <= 1'b0;
      lbus_rdn    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      // Bus outputs lag the state by one cycle so every output comes straight from a flop.
      lbus_di_a <= bus_di;
      lbus_wrn  <= bus_wrn;
      lbus_rdn  <= 1'b1;
      busy      <= (state != ST_IDLE);

      if (w_go) word_idx <= word_idx + IDX_W'(1);

      case (state)
        ST_IDLE: begin
          if (run) begin
            state     <= ST_PAUSE;
            pause_cnt <= '0;
            word_idx  <= '0;
          end
        end
        ST_PAUSE: begin
          if (pause_cnt == PAUSE_LAST) state <= ST_SEND_DATA;
          else pause_cnt <= pause_cnt + PCW'(1);
        end
        ST_SEND_DATA: begin
          if (w_done && (word_idx == WORDS)) begin
            state      <= ST_SEND_START;
            start_step <= 1'b0;
          end
        end
        ST_SEND_START: begin
          if (start_step) begin
            state <= ST_WAIT_END;
            timer <= '0;
          end else begin
            start_step <= 1'b1;
          end
        end
        ST_WAIT_END: begin
          // End strobe takes priority over a timeout on the same cycle.
          if (!tgt_endn) begin
            trace_cnt <= trace_cnt + 16'd1;
            operand   <= operand + 32'd1;
            state     <= end_state;
            pause_cnt <= '0;
            word_idx  <= '0;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            state       <= end_state;
            pause_cnt   <= '0;
            word_idx    <= '0;
          end else begin
            timer <= timer + TMW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
